// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray step scheduler.
// Holds the FSM state enum, Gray width and the Gray increment function.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int GRAY_W = 3;

  localparam logic [GRAY_W-1:0] GRAY_WRAP_FROM = 3'b100;

  // Next code in the 3-bit reflected Gray sequence.
  // Decode to binary, add one, re-encode.
  function automatic logic [GRAY_W-1:0] gray_next(
    input logic [GRAY_W-1:0] g
  );
    logic [GRAY_W-1:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    b    = b + 3'd1;
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_core.sv
// 3-bit Gray step counter with clear and enable.
// Ports: Clk, Reset_n, Clr, En in; Value (code), Wrap_p (wrap this edge) out.
module gray_core
  import gray_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Clr,
  input  logic              En,
  output logic [GRAY_W-1:0] Value,
  output logic              Wrap_p
);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Value <= '0;
    end else if (Clr) begin
      Value <= '0;
    end else if (En) begin
      Value <= gray_next(Value);
    end
  end

  // High for the one cycle whose closing edge steps 100 -> 000,
  // so a consumer can register the wrap on the same edge.
  assign Wrap_p = En && !Clr && (Value == GRAY_WRAP_FROM);

endmodule

// File: rtl/gray_step_sched.sv
// Round-robin scheduler sharing one Gray step counter among N requesters.
// Ports: Clk, Reset_n, Req[N], Len[N*LW] in; Gnt[N], Busy, Done, Gray, Wrap out.
module gray_step_sched
  import gray_pkg::*;
#(
  parameter int N  = 4,
  parameter int LW = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [N-1:0]      Req,
  input  logic [N*LW-1:0]   Len,
  output logic [N-1:0]      Gnt,
  output logic              Busy,
  output logic              Done,
  output logic [GRAY_W-1:0] Gray,
  output logic              Wrap
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t          state;
  state_t          state_nx;

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   idx;
  logic [LW-1:0]   rem;
  logic [N-1:0]    gnt_q;
  logic            wrap_q;

  logic            hit;
  logic [IW-1:0]   pick;
  logic [N-1:0]    pick_oh;
  logic [LW-1:0]   len_sel;
  logic [IW-1:0]   ptr_nx;

  logic            core_clr;
  logic            core_en;
  logic            core_wrap;
  logic [GRAY_W-1:0] core_val;

  // Circular priority search starting at ptr. The loop runs from the
  // farthest offset down so the nearest requester wins.
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    hit  = 1'b0;
    pick = '0;
    jj   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (Req[jj]) begin
        hit  = 1'b1;
        pick = jj;
      end
    end
  end

  always_comb begin
    pick_oh = '0;
    len_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pick == IW'(i)) begin
        pick_oh[i] = 1'b1;
        len_sel    = Len[i*LW +: LW];
      end
    end
  end

  assign ptr_nx = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (hit) begin
          state_nx = (len_sel == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (rem == LW'(1)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    Busy     = 1'b0;
    Done     = 1'b0;
    core_clr = 1'b0;
    core_en  = 1'b0;
    unique case (state)
      IDLE: begin
        core_clr = hit;
      end
      RUN: begin
        Busy    = 1'b1;
        core_en = 1'b1;
      end
      DONE: begin
        Busy = 1'b1;
        Done = 1'b1;
      end
      default: begin
        Busy = 1'b0;
      end
    endcase
  end

  // Job datapath: grant, remaining steps, pointer and sticky wrap.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gnt_q  <= '0;
      idx    <= '0;
      ptr    <= '0;
      rem    <= '0;
      wrap_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            gnt_q  <= pick_oh;
            idx    <= pick;
            rem    <= len_sel;
            wrap_q <= 1'b0;
          end
        end
        RUN: begin
          rem <= rem - LW'(1);
          if (core_wrap) begin
            wrap_q <= 1'b1;
          end
        end
        DONE: begin
          gnt_q <= '0;
          ptr   <= ptr_nx;
        end
        default: begin
          gnt_q <= '0;
        end
      endcase
    end
  end

  gray_core u_core (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Clr     (core_clr),
    .En      (core_en),
    .Value   (core_val),
    .Wrap_p  (core_wrap)
  );

  assign Gnt  = gnt_q;
  assign Gray = core_val;
  assign Wrap = wrap_q;

endmodule

// File: doc/gray_step_sched.md
# gray_step_sched

Round-robin scheduler that shares one 3-bit Gray step counter among `N` requesters. Each granted requester runs one job: the counter is cleared and advanced a requested number of steps. The scheduler then reports completion, the final Gray code and whether the count wrapped. The block sits between the client blocks and the Gray counter core, which it instantiates and sequences.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `LW`, default 4: width of each per-requester step-count field.
- `Clk`  in  1: clock, rising edge.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `Req`  in  N: per-requester request, level; held until `Done` is seen.
- `Len`  in  N*LW: packed step counts; field i = bits [i*LW +: LW]; sampled only at grant.
- `Gnt`  out  N: one-hot grant; high from the grant cycle through the `Done` cycle.
- `Busy`  out  1: high whenever the state is not IDLE.
- `Done`  out  1: one-cycle completion pulse, coincident with the final `Gnt`.
- `Gray`  out  3: current counter value.
- `Wrap`  out  1: sticky per job; set when the counter passes 100→000; cleared at grant.

## Operation
- Reset values: `Gnt`=0, `Busy`=0, `Done`=0, `Gray`=000, `Wrap`=0, state=IDLE, rr pointer=0, remaining count=0.
- Gray sequence: 000→001→011→010→110→111→101→100→000 (wrap).
- States:
  - IDLE: if any `Req` bit is set, choose the first set bit at or after the pointer (circular). On the next edge: register the one-hot `Gnt`, load rem=`Len[i]`, clear counter to 000, clear `Wrap`. Go to DONE if `Len[i]`=0, else RUN.
  - RUN: each cycle, step the counter and decrement rem. The edge where rem goes 1→0 moves to DONE.
  - DONE: `Done`=1, `Gnt` held, `Gray` final. Next edge: `Gnt`→0, pointer=(i+1) mod N, state IDLE.
- `Req` changes during RUN/DONE are ignored; jobs never abort.
- `Req` still high in IDLE after `Done` is a new request, subject to round-robin order.
- No grant is issued in the `Done` cycle; there is at least one IDLE cycle between jobs.
- `Wrap` is 1 iff `Len`≥8. Final `Gray` = Gray(`Len` mod 8).
- Reset mid-job: all outputs and state return to reset values immediately (async). No `Done` is issued for the aborted job.

## Timing
- `Req` seen in IDLE at edge 0 → `Gnt`/`Busy` high after edge 0.
- The counter advances on edges 1..L. `Done` is high in the cycle after edge L, or after edge 0 when L=0.
- `Gnt`/`Busy` fall after edge L+1.
- Job occupancy is L+2 cycles, including the IDLE arbitration cycle.
- `Gray` and `Wrap` are registered outputs with no combinational path from inputs.

## Structure
- Package `gray_pkg`:
  - state enum {IDLE, RUN, DONE};
  - constant `GRAY_W`=3;
  - function `gray_next` (3-bit in/out);
  - constant `GRAY_WRAP_FROM`=3'b100.
- Sub-module `gray_core`: 3-bit Gray counter.
  - Inputs: `Clk`, `Reset_n`, `Clr`, `En`.
  - Outputs: `Value` and a one-cycle `Wrap_p` pulse on 100→000.
  - `Clr` has priority over `En`.
- The scheduler holds the arbiter, pointer, remaining count, FSM and sticky `Wrap`.

## Test plan
- `Req`=0001, `Len[0]`=3 → `Gray` 001, 011, 010 on edges 1..3; `Done` after edge 3; `Wrap`=0; `Gnt`=0001 for 4 cycles.
- `Req`=0010, `Len[1]`=8 → `Gray` ends 000; `Wrap`=1; `Done` after edge 8.
- `Len[2]`=0, `Req`=0100 → `Gnt`=0100 and `Done` in the same cycle after edge 0; `Gray`=000; `Wrap`=0.
- `Req`=1111 held, all `Len`=1 → grant order 0001, 0010, 0100, 1000, 0001; one IDLE cycle between jobs.
- `Len[3]`=10 → final `Gray`=011, `Wrap`=1.
- Job running with `Len`=5, `Reset_n` pulled low after edge 2 → all outputs 0 immediately. After release, `Req`=0001 is granted first (pointer=0).
